// File: rtl/crc_ahb_sequencer.sv
// crc_ahb_sequencer
// AHB-Lite master that runs one complete CRC job on crc_ip per command:
// programs INIT, POL and CR, streams cmd_len words into DR, then reads DR
// back and offers the result on a valid/ready port. Exactly one transfer
// is outstanding at a time; an HRESP error aborts the job into DONE.
module crc_ahb_sequencer #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [31:0] OFF_DR        = 32'h0000_0000,
    parameter logic [31:0] OFF_CR        = 32'h0000_0008,
    parameter logic [31:0] OFF_INIT      = 32'h0000_0010,
    parameter logic [31:0] OFF_POL       = 32'h0000_0014,
    parameter logic [31:0] CR_RESET_MASK = 32'h0000_0001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_init,
    input  logic [31:0] cmd_pol,
    input  logic [31:0] cmd_cr,
    input  logic [15:0] cmd_len,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_error,
    output logic        HSELx,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HREADYOUT,
    input  logic        HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT_A = 4'd1,
        ST_INIT_D = 4'd2,
        ST_POL_A  = 4'd3,
        ST_POL_D  = 4'd4,
        ST_CR_A   = 4'd5,
        ST_CR_D   = 4'd6,
        ST_DWAIT  = 4'd7,
        ST_DR_A   = 4'd8,
        ST_DR_D   = 4'd9,
        ST_RD_A   = 4'd10,
        ST_RD_D   = 4'd11,
        ST_DONE   = 4'd12
    } state_t;

    state_t      state_q, state_d;

    // Command fields latched on the cmd handshake and the current data word
    logic [31:0] init_q;
    logic [31:0] pol_q;
    logic [31:0] cr_q;
    logic [31:0] data_q;
    logic [15:0] rem_q;

    // Registered bus outputs and their next-state values
    logic        hsel_q,   hsel_d;
    logic [31:0] haddr_q,  haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;

    // Registered handshake / result outputs
    logic        cmd_ready_q;
    logic        res_valid_q;
    logic        res_error_q;
    logic [31:0] res_data_q;

    logic        cmd_hs_s;
    logic        data_hs_s;
    logic        data_phase_s;
    logic        abort_s;
    logic        rd_done_s;

    assign cmd_hs_s     = cmd_valid && cmd_ready_q;
    assign data_hs_s    = data_valid && (state_q == ST_DWAIT);
    assign data_phase_s = (state_q == ST_INIT_D) || (state_q == ST_POL_D) ||
                          (state_q == ST_CR_D)   || (state_q == ST_DR_D)  ||
                          (state_q == ST_RD_D);
    // An error response wins over HREADYOUT: the job stops on the spot
    assign abort_s      = data_phase_s && HRESP;
    assign rd_done_s    = (state_q == ST_RD_D) && !HRESP && HREADYOUT;

    // Next-state selection; data phases hold while the slave inserts wait states
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = cmd_hs_s ? ST_INIT_A : ST_IDLE;
            ST_INIT_A: state_d = ST_INIT_D;
            ST_INIT_D: state_d = abort_s ? ST_DONE : (HREADYOUT ? ST_POL_A : ST_INIT_D);
            ST_POL_A:  state_d = ST_POL_D;
            ST_POL_D:  state_d = abort_s ? ST_DONE : (HREADYOUT ? ST_CR_A : ST_POL_D);
            ST_CR_A:   state_d = ST_CR_D;
            ST_CR_D:   state_d = abort_s ? ST_DONE :
                                 (HREADYOUT ? ((rem_q != 16'd0) ? ST_DWAIT : ST_RD_A) : ST_CR_D);
            ST_DWAIT:  state_d = data_hs_s ? ST_DR_A : ST_DWAIT;
            ST_DR_A:   state_d = ST_DR_D;
            ST_DR_D:   state_d = abort_s ? ST_DONE :
                                 (HREADYOUT ? ((rem_q != 16'd0) ? ST_DWAIT : ST_RD_A) : ST_DR_D);
            ST_RD_A:   state_d = ST_RD_D;
            ST_RD_D:   state_d = abort_s ? ST_DONE : (HREADYOUT ? ST_DONE : ST_RD_D);
            ST_DONE:   state_d = res_ready ? ST_IDLE : ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus values for the state being entered, so the bus pins come straight from flops
    always_comb begin
        hsel_d   = 1'b0;
        htrans_d = HTRANS_IDLE;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        case (state_d)
            ST_INIT_A: begin
                hsel_d   = 1'b1;
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = BASE_ADDR + OFF_INIT;
                hwrite_d = 1'b1;
            end
            ST_POL_A: begin
                hsel_d   = 1'b1;
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = BASE_ADDR + OFF_POL;
                hwrite_d = 1'b1;
            end
            ST_CR_A: begin
                hsel_d   = 1'b1;
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = BASE_ADDR + OFF_CR;
                hwrite_d = 1'b1;
            end
            ST_DR_A: begin
                hsel_d   = 1'b1;
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = BASE_ADDR + OFF_DR;
                hwrite_d = 1'b1;
            end
            ST_RD_A: begin
                hsel_d   = 1'b1;
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = BASE_ADDR + OFF_DR;
                hwrite_d = 1'b0;
            end
            ST_INIT_D: hwdata_d = init_q;
            ST_POL_D:  hwdata_d = pol_q;
            ST_CR_D:   hwdata_d = cr_q | CR_RESET_MASK;
            ST_DR_D:   hwdata_d = data_q;
            default:   hwdata_d = hwdata_q;
        endcase
    end

    // FSM state, latched command, word counter and all registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            init_q      <= 32'h0000_0000;
            pol_q       <= 32'h0000_0000;
            cr_q        <= 32'h0000_0000;
            data_q      <= 32'h0000_0000;
            rem_q       <= 16'h0000;
            hsel_q      <= 1'b0;
            haddr_q     <= 32'h0000_0000;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'h0000_0000;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_error_q <= 1'b0;
            res_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);
            if (cmd_hs_s) begin
                init_q <= cmd_init;
                pol_q  <= cmd_pol;
                cr_q   <= cmd_cr;
                rem_q  <= cmd_len;
            end else if (data_hs_s) begin
                data_q <= data_in;
                rem_q  <= rem_q - 16'd1;
            end
            if (abort_s) begin
                res_data_q  <= 32'h0000_0000;
                res_error_q <= 1'b1;
            end else if (rd_done_s) begin
                res_data_q  <= HRDATA;
                res_error_q <= 1'b0;
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign data_ready = (state_q == ST_DWAIT);
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_error  = res_error_q;
    assign HSELx      = hsel_q;
    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = HSIZE_WORD;
    assign HWDATA     = hwdata_q;
    assign HREADY     = HREADYOUT;

endmodule

// File: tb/tb_crc_ahb_sequencer.sv
// tb_crc_ahb_sequencer
// Directed bench: a behavioural crc_ip slave with wait-state and error
// injection, a valid/ready word source with optional gaps, and a linear
// sequence of jobs checked against hand-derived latencies and CRC values.
module tb_crc_ahb_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_init;
    logic [31:0] cmd_pol;
    logic [31:0] cmd_cr;
    logic [15:0] cmd_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_error;
    logic        HSELx;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model state (owned by the slave process)
    logic [31:0] init_r, pol_r, cr_r, crc_r;
    int          dr_count = 0;
    int          nonseq_cnt = 0;
    int          hwdata_unstable = 0;
    bit          dp_active = 1'b0;
    bit          dp_write, dp_first;
    logic [31:0] dp_addr, wd_first;
    int          dp_wait;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    bit          log_wr[$];

    // Slave controls (owned by the stimulus block)
    int wait_cfg = 0;
    int err_at   = 0;

    // Word source: stimulus pushes into src_mem and moves src_start, source owns src_rd
    logic [31:0] src_mem[$];
    int          src_start = 0;
    int          src_rd = 0;
    int          src_gap = 0;
    int          gap_cnt = 0;
    bit          hs_next = 1'b0;

    int          lat, lb, nb, ub, sb;
    logic [31:0] exp_v;

    crc_ahb_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_init(cmd_init), .cmd_pol(cmd_pol), .cmd_cr(cmd_cr), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
        .HSELx(HSELx), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // MSB-first CRC-32 step over one word
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] p,
                                             input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int i = 0; i < 32; i++) begin
            r = r[31] ? ((r << 1) ^ p) : (r << 1);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
        check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_res_valid"},  32'(res_valid),  32'd0);
        check({tag, "_res_data"},   res_data,        32'd0);
        check({tag, "_res_error"},  32'(res_error),  32'd0);
        check({tag, "_hsel"},       32'(HSELx),      32'd0);
        check({tag, "_haddr"},      HADDR,           32'd0);
        check({tag, "_htrans"},     32'(HTRANS),     32'd0);
        check({tag, "_hwrite"},     32'(HWRITE),     32'd0);
        check({tag, "_hsize"},      32'(HSIZE),      32'd2);
        check({tag, "_hwdata"},     HWDATA,          32'd0);
    endtask

    task automatic check_xfer(input string tag, input int idx, input logic [31:0] addr,
                              input bit wr, input logic [31:0] data);
        check({tag, "_addr"},  log_addr[idx],     addr);
        check({tag, "_write"}, 32'(log_wr[idx]),  32'(wr));
        check({tag, "_data"},  log_data[idx],     data);
    endtask

    // Issues a command at posedge+1 and counts cycles until res_valid (bounded)
    task automatic do_cmd(input logic [31:0] ini, input logic [31:0] pol, input logic [31:0] cr,
                          input logic [15:0] len, output int lat_o);
        check("cmd_ready_pre", 32'(cmd_ready), 32'd1);
        cmd_init  = ini;
        cmd_pol   = pol;
        cmd_cr    = cr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        lat_o = 1;
        while (res_valid !== 1'b1 && lat_o < 500) begin
            @(posedge HCLK); #1;
            lat_o++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(posedge HCLK); #1;
            k++;
        end
    endtask

    // Handshake that will complete at the coming posedge
    always @(negedge HCLK) hs_next = data_valid && data_ready;

    // Word source: advances on handshakes, then idles src_gap cycles before the next word
    initial begin
        data_valid = 1'b0;
        data_in    = 32'h0;
        forever begin
            @(posedge HCLK); #2;
            if (hs_next) begin
                src_rd++;
                gap_cnt = src_gap;
            end
            if (src_rd < src_start) src_rd = src_start;
            if (src_rd < src_mem.size() && gap_cnt == 0) begin
                data_valid = 1'b1;
                data_in    = src_mem[src_rd];
            end else begin
                data_valid = 1'b0;
                if (gap_cnt > 0) gap_cnt--;
            end
        end
    end

    // crc_ip slave model, evaluated mid-cycle when DUT outputs are stable
    initial begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        init_r = 32'h0; pol_r = 32'h0; cr_r = 32'h0; crc_r = 32'h0;
        forever begin
            @(negedge HCLK or negedge HRESETn);
            if (HRESETn !== 1'b1) begin
                dp_active = 1'b0;
                HREADYOUT = 1'b1;
                HRESP     = 1'b0;
            end else begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b0;
                if (dp_active) begin
                    if (dp_first) begin
                        wd_first = HWDATA;
                        dp_first = 1'b0;
                    end else if (dp_write && HWDATA !== wd_first) begin
                        hwdata_unstable++;
                    end
                    if (dp_wait > 0) begin
                        HREADYOUT = 1'b0;
                        dp_wait--;
                    end else begin
                        dp_active = 1'b0;
                        if (dp_write && dp_addr == 32'h0) dr_count++;
                        if (dp_write && dp_addr == 32'h0 && dr_count == err_at) begin
                            HRESP = 1'b1;
                        end else if (dp_write) begin
                            log_addr.push_back(dp_addr);
                            log_wr.push_back(1'b1);
                            log_data.push_back(HWDATA);
                            if (dp_addr == 32'h10) init_r = HWDATA;
                            else if (dp_addr == 32'h14) pol_r = HWDATA;
                            else if (dp_addr == 32'h08) begin
                                cr_r = HWDATA;
                                if (HWDATA[0]) crc_r = init_r;
                            end else if (dp_addr == 32'h00) crc_r = crc_step(crc_r, pol_r, HWDATA);
                        end else begin
                            HRDATA = crc_r;
                            log_addr.push_back(dp_addr);
                            log_wr.push_back(1'b0);
                            log_data.push_back(crc_r);
                        end
                    end
                end
                if (HSELx === 1'b1 && HTRANS === 2'b10) begin
                    nonseq_cnt++;
                    dp_active = 1'b1;
                    dp_addr   = HADDR;
                    dp_write  = HWRITE;
                    dp_wait   = wait_cfg;
                    dp_first  = 1'b1;
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_init  = 32'h0;
        cmd_pol   = 32'h0;
        cmd_cr    = 32'h0;
        cmd_len   = 16'h0;
        res_ready = 1'b1;

        // Reset values, during and after reset
        #12;
        check_reset("rst_hold");
        @(posedge HCLK); #3;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_reset("rst_rel");
        check("hready_pass", 32'(HREADY), 32'(HREADYOUT));

        // Basic job: one word, zero-wait slave
        lb = log_addr.size();
        src_start = src_mem.size();
        src_mem.push_back(32'h1234_5678);
        do_cmd(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h0000_0000, 16'd1, lat);
        exp_v = crc_step(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h1234_5678);
        check("basic_lat", 32'(lat), 32'd12);
        check("basic_res", res_data, exp_v);
        check("basic_err", 32'(res_error), 32'd0);
        check("basic_nxfer", 32'(log_addr.size() - lb), 32'd5);
        check_xfer("basic_init", lb,     32'h10, 1'b1, 32'hFFFF_FFFF);
        check_xfer("basic_pol",  lb + 1, 32'h14, 1'b1, 32'h04C1_1DB7);
        check_xfer("basic_cr",   lb + 2, 32'h08, 1'b1, 32'h0000_0001);
        check_xfer("basic_dr",   lb + 3, 32'h00, 1'b1, 32'h1234_5678);
        check_xfer("basic_rd",   lb + 4, 32'h00, 1'b0, exp_v);
        wait_idle();

        // Empty job: no DR writes, result is the reloaded INIT value
        lb = log_addr.size();
        do_cmd(32'hA5A5_0F0F, 32'h04C1_1DB7, 32'h0000_0100, 16'd0, lat);
        check("empty_lat", 32'(lat), 32'd9);
        check("empty_res", res_data, 32'hA5A5_0F0F);
        check("empty_nxfer", 32'(log_addr.size() - lb), 32'd4);
        check_xfer("empty_cr", lb + 2, 32'h08, 1'b1, 32'h0000_0101);
        check_xfer("empty_rd", lb + 3, 32'h00, 1'b0, 32'hA5A5_0F0F);
        wait_idle();

        // Wait states: two stall cycles in every data phase, three words
        lb = log_addr.size();
        ub = hwdata_unstable;
        wait_cfg = 2;
        src_start = src_mem.size();
        src_mem.push_back(32'hDEAD_BEEF);
        src_mem.push_back(32'h0000_0001);
        src_mem.push_back(32'h8000_0000);
        do_cmd(32'hFFFF_FFFF, 32'h1EDC_6F41, 32'h0000_0000, 16'd3, lat);
        exp_v = crc_step(crc_step(crc_step(32'hFFFF_FFFF, 32'h1EDC_6F41, 32'hDEAD_BEEF),
                                  32'h1EDC_6F41, 32'h0000_0001), 32'h1EDC_6F41, 32'h8000_0000);
        check("wait_lat", 32'(lat), 32'd32);
        check("wait_res", res_data, exp_v);
        check("wait_hwdata_stable", 32'(hwdata_unstable - ub), 32'd0);
        check_xfer("wait_dr0", lb + 3, 32'h00, 1'b1, 32'hDEAD_BEEF);
        check_xfer("wait_dr2", lb + 5, 32'h00, 1'b1, 32'h8000_0000);
        wait_idle();
        wait_cfg = 0;

        // Error on the second DR write of a four-word job
        nb = nonseq_cnt;
        err_at = dr_count + 2;
        src_start = src_mem.size();
        sb = src_start;
        src_mem.push_back(32'h1111_1111);
        src_mem.push_back(32'h2222_2222);
        src_mem.push_back(32'h3333_3333);
        src_mem.push_back(32'h4444_4444);
        do_cmd(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h0000_0000, 16'd4, lat);
        check("err_lat", 32'(lat), 32'd13);
        check("err_flag", 32'(res_error), 32'd1);
        check("err_data", res_data, 32'd0);
        check("err_consumed", 32'(src_rd - sb), 32'd2);
        check("err_nonseq", 32'(nonseq_cnt - nb), 32'd5);
        repeat (4) @(posedge HCLK);
        #1;
        check("err_nonseq_after", 32'(nonseq_cnt - nb), 32'd5);
        check("err_consumed_after", 32'(src_rd - sb), 32'd2);
        err_at = 0;
        wait_idle();

        // Back-pressure: 3-cycle data gaps, result held for 5 cycles
        lb = log_addr.size();
        src_gap = 3;
        res_ready = 1'b0;
        src_start = src_mem.size();
        src_mem.push_back(32'hCAFE_0001);
        src_mem.push_back(32'hCAFE_0002);
        do_cmd(32'h0000_0000, 32'h04C1_1DB7, 32'h0000_0000, 16'd2, lat);
        exp_v = crc_step(crc_step(32'h0000_0000, 32'h04C1_1DB7, 32'hCAFE_0001),
                         32'h04C1_1DB7, 32'hCAFE_0002);
        check("bp_lat", 32'(lat), 32'd16);
        check("bp_res", res_data, exp_v);
        check_xfer("bp_dr0", lb + 3, 32'h00, 1'b1, 32'hCAFE_0001);
        check_xfer("bp_dr1", lb + 4, 32'h00, 1'b1, 32'hCAFE_0002);
        for (int i = 0; i < 5; i++) begin
            @(posedge HCLK); #1;
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_data", res_data, exp_v);
            check("bp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge HCLK); #1;
        check("bp_taken_valid", 32'(res_valid), 32'd0);
        check("bp_taken_cmd_ready", 32'(cmd_ready), 32'd1);
        src_gap = 0;

        // Reset pulsed during DR_D of a one-word job
        lb = log_addr.size();
        src_start = src_mem.size();
        src_mem.push_back(32'h5555_AAAA);
        cmd_init  = 32'hFFFF_FFFF;
        cmd_pol   = 32'h04C1_1DB7;
        cmd_cr    = 32'h0000_0000;
        cmd_len   = 16'd1;
        cmd_valid = 1'b1;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        repeat (8) @(posedge HCLK);
        #1;
        check("mid_in_dr_d_hwdata", HWDATA, 32'h5555_AAAA);
        check("mid_in_dr_d_htrans", 32'(HTRANS), 32'd0);
        HRESETn = 1'b0;
        #1;
        check_reset("rst_mid");
        @(posedge HCLK); #3;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_reset("rst_mid_rel");
        check("mid_nxfer", 32'(log_addr.size() - lb), 32'd3);

        // Job after the mid-job reset
        lb = log_addr.size();
        src_start = src_mem.size();
        src_mem.push_back(32'h0BAD_F00D);
        do_cmd(32'h1234_0000, 32'h04C1_1DB7, 32'h0000_0000, 16'd1, lat);
        exp_v = crc_step(32'h1234_0000, 32'h04C1_1DB7, 32'h0BAD_F00D);
        check("post_rst_lat", 32'(lat), 32'd12);
        check("post_rst_res", res_data, exp_v);
        check("post_rst_err", 32'(res_error), 32'd0);
        check_xfer("post_rst_dr", lb + 3, 32'h00, 1'b1, 32'h0BAD_F00D);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
